// File: rtl/ml_dense_engine_pkg.sv
// Shared constants and types for the dense-layer engine.
//   state_t    : layer sequencer states
//   DATA_W     : width of every packed operand / result element
//   PROD_W     : width of one signed 8x8 product
//   SAT_MAX/MIN: clamp limits of the 8-bit signed result
//   acc_width(): accumulator width that cannot wrap for n_in products
package ml_dense_engine_pkg;

  localparam int DATA_W  = 8;
  localparam int PROD_W  = 2 * DATA_W;
  localparam int SAT_MAX = 127;
  localparam int SAT_MIN = -128;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_LOAD = 3'd1,
    ST_MAC  = 3'd2,
    ST_FIN  = 3'd3,
    ST_DONE = 3'd4
  } state_t;

  function automatic int acc_width(input int n_in);
    return PROD_W + $clog2(n_in) + 1;
  endfunction

endpackage

// File: rtl/ml_dense_engine_mac_unit.sv
// Signed multiply-accumulate and output post-processing for one neuron.
// Ports:
//   usb_clk, reset_i : clock, synchronous active-high reset
//   clr_i            : zero the accumulator (wins over en_i)
//   en_i             : add x_i*w_i into the accumulator this cycle
//   x_i, w_i         : signed 8-bit operands
//   b_i              : signed 8-bit bias for the current neuron
//   y_o              : combinational result act(sat((acc + b<<frac) >>> frac))
module ml_dense_engine_mac_unit
  import ml_dense_engine_pkg::*;
#(
  parameter int pINPUTCNT = 4,
  parameter int pFRAC     = 4,
  parameter int pRELU     = 1
) (
  input  logic              usb_clk,
  input  logic              reset_i,
  input  logic              clr_i,
  input  logic              en_i,
  input  logic [DATA_W-1:0] x_i,
  input  logic [DATA_W-1:0] w_i,
  input  logic [DATA_W-1:0] b_i,
  output logic [DATA_W-1:0] y_o
);

  localparam int ACC_W = acc_width(pINPUTCNT);
  // One extra bit so acc + shifted bias cannot overflow before the shift.
  localparam int R_W   = ACC_W + 1;

  localparam logic signed [R_W-1:0] SAT_HI = R_W'(SAT_MAX);
  localparam logic signed [R_W-1:0] SAT_LO = R_W'(SAT_MIN);

  logic signed [PROD_W-1:0] prod;
  logic signed [ACC_W-1:0]  acc;
  logic signed [R_W-1:0]    bias_sh;
  logic signed [R_W-1:0]    sum;
  logic signed [R_W-1:0]    r_sh;
  logic signed [R_W-1:0]    r_act;

  assign prod = $signed(x_i) * $signed(w_i);

  always_ff @(posedge usb_clk) begin
    if (reset_i) begin
      acc <= '0;
    end else if (clr_i) begin
      acc <= '0;
    end else if (en_i) begin
      acc <= acc + ACC_W'(prod);
    end
  end

  always_comb begin
    bias_sh = R_W'($signed(b_i)) <<< pFRAC;
    sum     = R_W'(acc) + bias_sh;
    r_sh    = sum >>> pFRAC;
    r_act   = r_sh;
    if ((pRELU != 0) && (r_sh < 0)) begin
      r_act = '0;
    end
    if (r_act > SAT_HI) begin
      y_o = 8'h7F;
    end else if (r_act < SAT_LO) begin
      y_o = 8'h80;
    end else begin
      y_o = r_act[DATA_W-1:0];
    end
  end

endmodule

// File: rtl/ml_dense_engine.sv
// Fully-connected layer core: y[o] = act(sum_i x[i]*w[o*IN+i] + b[o]),
// one MAC per cycle, operands snapshotted at start.
// Ports:
//   usb_clk    : clock shared with the register block
//   reset_i    : synchronous active-high reset, aborts a run
//   start_i    : 1-cycle pulse, accepted only in IDLE
//   inputs_i   : x[i] at [8i+7:8i]
//   weights_i  : w[k] at [8k+7:8k], k = o*pINPUTCNT+i
//   bias_i     : b[o] at [8o+7:8o], only the first pOUTPUTCNT slots used
//   outputs_o  : y[o] at [8o+7:8o], updated together when done_o pulses
//   busy_o     : high while a layer is being computed
//   done_o     : 1-cycle pulse, outputs_o holds the new result
//
// state | meaning
// IDLE  | waiting for start_i
// LOAD  | snapshot operand buses, clear counters and accumulator
// MAC   | accumulate x[i]*w[o*IN+i], one input per cycle
// FIN   | post-process neuron o into the shadow vector, advance o
// DONE  | result visible on outputs_o, done_o pulse
module ml_dense_engine
  import ml_dense_engine_pkg::*;
#(
  parameter int pINPUTCNT  = 4,
  parameter int pOUTPUTCNT = 4,
  parameter int pWEIGHTCNT = 16,
  parameter int pBIASCNT   = 16,
  parameter int pFRAC      = 4,
  parameter int pRELU      = 1
) (
  input  logic                           usb_clk,
  input  logic                           reset_i,
  input  logic                           start_i,
  input  logic [DATA_W*pINPUTCNT-1:0]    inputs_i,
  input  logic [DATA_W*pWEIGHTCNT-1:0]   weights_i,
  input  logic [DATA_W*pBIASCNT-1:0]     bias_i,
  output logic [DATA_W*pOUTPUTCNT-1:0]   outputs_o,
  output logic                           busy_o,
  output logic                           done_o
);

  localparam int IW = (pINPUTCNT  > 1) ? $clog2(pINPUTCNT)  : 1;
  localparam int OW = (pOUTPUTCNT > 1) ? $clog2(pOUTPUTCNT) : 1;
  localparam int KW = (pWEIGHTCNT > 1) ? $clog2(pWEIGHTCNT) : 1;

  generate
    if (pWEIGHTCNT != pINPUTCNT * pOUTPUTCNT) begin : g_bad_wcnt
      $error("ml_dense_engine: pWEIGHTCNT must equal pINPUTCNT*pOUTPUTCNT");
    end
    if (pBIASCNT < pOUTPUTCNT) begin : g_bad_bcnt
      $error("ml_dense_engine: pBIASCNT must be >= pOUTPUTCNT");
    end
    if (pBIASCNT > pOUTPUTCNT) begin : g_bias_spare
      // Spare bias slots exist on the bus but carry no meaning here.
      logic bias_unused;
      assign bias_unused = ^bias_i[DATA_W*pBIASCNT-1:DATA_W*pOUTPUTCNT];
    end
  endgenerate

  state_t state;
  state_t state_nxt;

  logic [DATA_W*pINPUTCNT-1:0]  x_q;
  logic [DATA_W*pWEIGHTCNT-1:0] w_q;
  logic [DATA_W*pOUTPUTCNT-1:0] b_q;
  logic [DATA_W*pOUTPUTCNT-1:0] shadow;
  logic [DATA_W*pOUTPUTCNT-1:0] shadow_nxt;

  logic [IW-1:0] i_cnt;
  logic [OW-1:0] o_cnt;
  logic [KW-1:0] w_idx;

  logic              last_i;
  logic              last_o;
  logic              mac_clr;
  logic              mac_en;
  logic [DATA_W-1:0] x_sel;
  logic [DATA_W-1:0] w_sel;
  logic [DATA_W-1:0] b_sel;
  logic [DATA_W-1:0] y_fin;

  assign last_i = (i_cnt == IW'(pINPUTCNT - 1));
  assign last_o = (o_cnt == OW'(pOUTPUTCNT - 1));

  assign x_sel = x_q[DATA_W*i_cnt +: DATA_W];
  assign w_sel = w_q[DATA_W*w_idx +: DATA_W];
  assign b_sel = b_q[DATA_W*o_cnt +: DATA_W];

  always_ff @(posedge usb_clk) begin
    if (reset_i) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    mac_clr   = 1'b0;
    mac_en    = 1'b0;
    busy_o    = 1'b0;
    done_o    = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start_i) begin
          state_nxt = ST_LOAD;
        end
      end
      ST_LOAD: begin
        busy_o    = 1'b1;
        mac_clr   = 1'b1;
        state_nxt = ST_MAC;
      end
      ST_MAC: begin
        busy_o = 1'b1;
        mac_en = 1'b1;
        if (last_i) begin
          state_nxt = ST_FIN;
        end
      end
      ST_FIN: begin
        busy_o    = 1'b1;
        mac_clr   = 1'b1;
        state_nxt = last_o ? ST_DONE : ST_MAC;
      end
      ST_DONE: begin
        done_o    = 1'b1;
        state_nxt = ST_IDLE;
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  always_comb begin
    shadow_nxt = shadow;
    shadow_nxt[DATA_W*o_cnt +: DATA_W] = y_fin;
  end

  // outputs_o is loaded on the edge into DONE so the new vector is already
  // visible in the cycle done_o is high.
  always_ff @(posedge usb_clk) begin
    if (reset_i) begin
      x_q       <= '0;
      w_q       <= '0;
      b_q       <= '0;
      shadow    <= '0;
      outputs_o <= '0;
      i_cnt     <= '0;
      o_cnt     <= '0;
      w_idx     <= '0;
    end else begin
      case (state)
        ST_LOAD: begin
          x_q   <= inputs_i;
          w_q   <= weights_i;
          b_q   <= bias_i[DATA_W*pOUTPUTCNT-1:0];
          i_cnt <= '0;
          o_cnt <= '0;
          w_idx <= '0;
        end
        ST_MAC: begin
          if (!last_i) begin
            i_cnt <= i_cnt + 1'b1;
          end
          w_idx <= w_idx + 1'b1;
        end
        ST_FIN: begin
          i_cnt  <= '0;
          shadow <= shadow_nxt;
          if (last_o) begin
            outputs_o <= shadow_nxt;
          end else begin
            o_cnt <= o_cnt + 1'b1;
          end
        end
        default: begin
        end
      endcase
    end
  end

  ml_dense_engine_mac_unit #(
    .pINPUTCNT (pINPUTCNT),
    .pFRAC     (pFRAC),
    .pRELU     (pRELU)
  ) u_mac (
    .usb_clk (usb_clk),
    .reset_i (reset_i),
    .clr_i   (mac_clr),
    .en_i    (mac_en),
    .x_i     (x_sel),
    .w_i     (w_sel),
    .b_i     (b_sel),
    .y_o     (y_fin)
  );

endmodule

// File: tb/tb_ml_dense_engine.sv
module tb_ml_dense_engine;

  logic         usb_clk;
  logic         reset_i;
  logic         start_i;
  logic [31:0]  inputs_i;
  logic [127:0] weights_i;
  logic [127:0] bias_i;
  logic [31:0]  outputs_o;
  logic         busy_o;
  logic         done_o;
  logic [31:0]  outputs_nr;
  logic         busy_nr;
  logic         done_nr;

  int n_vec;
  int n_err;

  ml_dense_engine u_dut (
    .usb_clk   (usb_clk),
    .reset_i   (reset_i),
    .start_i   (start_i),
    .inputs_i  (inputs_i),
    .weights_i (weights_i),
    .bias_i    (bias_i),
    .outputs_o (outputs_o),
    .busy_o    (busy_o),
    .done_o    (done_o)
  );

  ml_dense_engine #(.pRELU(0)) u_dut_nr (
    .usb_clk   (usb_clk),
    .reset_i   (reset_i),
    .start_i   (start_i),
    .inputs_i  (inputs_i),
    .weights_i (weights_i),
    .bias_i    (bias_i),
    .outputs_o (outputs_nr),
    .busy_o    (busy_nr),
    .done_o    (done_nr)
  );

  initial usb_clk = 1'b0;
  always #5 usb_clk = ~usb_clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Start a layer and watch it for 40 cycles. Cycle 0 is the start edge;
  // busy must be high exactly in cycles 1..21 and done only in cycle 22.
  task automatic run_layer(input string tag, input logic [31:0] x, input logic [127:0] w,
                           input logic [127:0] b, input logic [31:0] exp_y,
                           input logic [31:0] exp_nr, input bit poke, input bit chg);
    int   cyc;
    int   n_done;
    int   done_cyc;
    bit   busy_bad;
    bit   hold_bad;
    logic [31:0] got_y;
    logic [31:0] got_nr;
    n_done   = 0;
    done_cyc = 0;
    busy_bad = 0;
    hold_bad = 0;
    got_y    = '0;
    got_nr   = '0;
    @(negedge usb_clk);
    inputs_i  = x;
    weights_i = w;
    bias_i    = b;
    start_i   = 1'b1;
    @(posedge usb_clk);
    #1;
    start_i = 1'b0;
    for (cyc = 1; cyc <= 40; cyc++) begin
      if (done_o) begin
        n_done++;
        done_cyc = cyc;
        got_y    = outputs_o;
        got_nr   = outputs_nr;
      end
      if (busy_o !== ((cyc >= 1) && (cyc <= 21))) busy_bad = 1;
      if ((n_done > 0) && !done_o && (outputs_o !== got_y)) hold_bad = 1;
      start_i = (poke && ((cyc == 5) || (cyc == 22))) ? 1'b1 : 1'b0;
      if (chg && (cyc == 3)) begin
        inputs_i  = $urandom;
        weights_i = {$urandom, $urandom, $urandom, $urandom};
        bias_i    = {$urandom, $urandom, $urandom, $urandom};
      end
      @(posedge usb_clk);
      #1;
    end
    start_i = 1'b0;
    check_val({tag, "_done_cyc"}, 32'(done_cyc), 32'd22);
    check_val({tag, "_done_cnt"}, 32'(n_done), 32'd1);
    check_val({tag, "_y"}, got_y, exp_y);
    check_val({tag, "_y_norelu"}, got_nr, exp_nr);
    check_val({tag, "_busy"}, {31'd0, busy_bad}, 32'd0);
    check_val({tag, "_hold"}, {31'd0, hold_bad}, 32'd0);
  endtask

  task automatic reset_mid_run();
    int cyc;
    int n_done;
    n_done = 0;
    @(negedge usb_clk);
    inputs_i  = 32'h10101010;
    weights_i = {16{8'h10}};
    bias_i    = '0;
    start_i   = 1'b1;
    @(posedge usb_clk);
    #1;
    start_i = 1'b0;
    for (cyc = 1; cyc <= 40; cyc++) begin
      if (done_o) n_done++;
      if (cyc == 11) begin
        check_val("rst_mid_out", outputs_o, 32'h0);
        check_val("rst_mid_out_nr", outputs_nr, 32'h0);
        check_val("rst_mid_busy", {31'd0, busy_o}, 32'd0);
      end
      reset_i = (cyc == 10) ? 1'b1 : 1'b0;
      @(posedge usb_clk);
      #1;
    end
    reset_i = 1'b0;
    check_val("rst_mid_no_done", 32'(n_done), 32'd0);
  endtask

  initial begin
    n_vec     = 0;
    n_err     = 0;
    reset_i   = 1'b1;
    start_i   = 1'b0;
    inputs_i  = '0;
    weights_i = '0;
    bias_i    = '0;
    repeat (3) @(posedge usb_clk);
    #1;
    check_val("rst_out", outputs_o, 32'h0);
    check_val("rst_busy", {31'd0, busy_o}, 32'd0);
    check_val("rst_done", {31'd0, done_o}, 32'd0);
    check_val("rst_out_nr", outputs_nr, 32'h0);
    reset_i = 1'b0;
    repeat (2) @(posedge usb_clk);

    // 1.0 * 1.0 * 4 = 4.0 -> 0x40
    run_layer("ones", 32'h10101010, {16{8'h10}}, '0, 32'h40404040, 32'h40404040, 0, 0);
    // -4.0: ReLU clamps to 0, identity gives 0xC0
    run_layer("neg", 32'h10101010, {16{8'hF0}}, '0, 32'h00000000, 32'hC0C0C0C0, 0, 0);
    // 4*127*127 >> 4 = 4032 -> saturates to 0x7F
    run_layer("sat", 32'h7F7F7F7F, {16{8'h7F}}, '0, 32'h7F7F7F7F, 32'h7F7F7F7F, 0, 0);
    // x = {1.0, 2.0, -1.0, 0.5}; y0 = 2.5, y1 = 1.0+1/16, y2 = -1.0, y3 = 0.5-1/16
    run_layer("mix", 32'h08F02010, 128'h10000000_00100000_00000010_10101010,
              128'hA5A5A5A5_A5A5A5A5_A5A5A5A5_FF000100, 32'h07001128, 32'h07F01128, 0, 0);
    // bias-only result; buses scrambled and start poked while running / in DONE
    run_layer("bias", 32'h00000000, {16{8'hA5}},
              128'hDEADBEEF_CAFEF00D_12345678_04030201, 32'h04030201, 32'h04030201, 1, 1);

    reset_mid_run();
    run_layer("recover", 32'h10101010, {16{8'h10}}, '0, 32'h40404040, 32'h40404040, 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
